// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one multi-cycle sum adder among N requesters; grant +1 cycle, result +1 cycle after sum_busy falls.
// Requesters hold req/operands until done; an adder that never goes busy is abandoned after TIMEOUT cycles with an err pulse.
module sum_arbiter #(
  parameter int N       = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   done,
  output logic [W-1:0]   res,
  output logic           err,
  output logic [3:0]     gnt_id,
  output logic           busy_o,
  output logic           sum_start,
  output logic [W-1:0]   sum_a,
  output logic [W-1:0]   sum_b,
  input  logic           sum_busy,
  input  logic [W-1:0]   sum_y
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     ptr;
  logic [3:0]     win_id;
  logic           win_vld;
  logic [4:0]     win_off;
  logic [4:0]     win_sum;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [CW-1:0]  cnt;
  logic           timeout;
  logic [3:0]     ptr_after;

  // Rotate requests so bit 0 is the pointer's requester; lowest set bit wins.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    win_vld = |req;
    win_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = 5'(k);
    end
    win_sum = {1'b0, ptr} + win_off;
    if (win_sum >= 5'(N)) win_sum = win_sum - 5'(N);
    win_id = win_sum[3:0];
  end

  assign timeout   = (state == ISSUE) && !sum_busy && (cnt == CW'(TIMEOUT - 1));
  assign ptr_after = (gnt_id == 4'(N - 1)) ? 4'd0 : gnt_id + 4'd1;

  always_comb begin
    state_nxt = state;
    busy_o    = (state != IDLE);
    sum_start = (state == ISSUE);
    done      = '0;
    case (state)
      IDLE:  if (win_vld) state_nxt = ISSUE;
      ISSUE: begin
        if (sum_busy)     state_nxt = WAIT;
        else if (timeout) state_nxt = IDLE;
      end
      WAIT:  if (!sum_busy) state_nxt = DONE;
      DONE: begin
        done      = N'(1) << gnt_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      res    <= '0;
      gnt_id <= '0;
      sum_a  <= '0;
      sum_b  <= '0;
    end else begin
      state <= state_nxt;
      err   <= timeout;
      cnt   <= (state == ISSUE) ? cnt + CW'(1) : '0;
      if (state == IDLE && win_vld) begin
        gnt_id <= win_id;
        sum_a  <= a_in[win_id*W +: W];
        sum_b  <= b_in[win_id*W +: W];
      end
      if (state == WAIT && !sum_busy) res <= sum_y;
      if (timeout || state == DONE) ptr <= ptr_after;
    end
  end

endmodule

// File: tb/tb_sum_arbiter.sv
// Directed bench for sum_arbiter with a 3-cycle behavioural adder that can be forced to never go busy.
module tb_sum_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in, b_in;
  logic [N-1:0]   done;
  logic [W-1:0]   res;
  logic           err;
  logic [3:0]     gnt_id;
  logic           busy_o, sum_start;
  logic [W-1:0]   sum_a, sum_b;
  logic           sum_busy;
  logic [W-1:0]   sum_y;

  int checks = 0, failures = 0;
  int start_rises = 0, err_cnt = 0, done_cnt = 0;
  logic start_q = 1'b0;
  logic stuck = 1'b0;

  sum_arbiter #(.N(N), .W(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .done(done), .res(res), .err(err), .gnt_id(gnt_id), .busy_o(busy_o),
    .sum_start(sum_start), .sum_a(sum_a), .sum_b(sum_b),
    .sum_busy(sum_busy), .sum_y(sum_y)
  );

  always #5 clk = ~clk;

  // Adder: busy for 3 cycles after an accepted start; y is junk until busy falls.
  logic [W-1:0] macc;
  int mcnt;
  always @(posedge clk) begin
    if (rst) begin
      sum_busy <= 1'b0; mcnt <= 0; sum_y <= '0; macc <= '0;
    end else if (!sum_busy && sum_start && !stuck) begin
      sum_busy <= 1'b1; mcnt <= 3; macc <= sum_a + sum_b; sum_y <= 16'hdead;
    end else if (sum_busy) begin
      if (mcnt == 1) begin sum_busy <= 1'b0; sum_y <= macc; end
      mcnt <= mcnt - 1;
    end
  end

  always @(negedge clk) begin
    if (sum_start && !start_q) start_rises++;
    start_q = sum_start;
    if (err) err_cnt++;
    if (done != 0) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic wait_done(input string tag, input logic [N-1:0] exp_done, input logic [W-1:0] exp_res);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done != 0) break;
    end
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_res"}, 32'(res), 32'(exp_res));
  endtask

  task automatic wait_in_wait(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (seen && busy_o && !sum_start) break;
      if (sum_start) seen = 1'b1;
    end
    check({tag, "_reach_wait"}, 32'(busy_o && !sum_start), 32'd1);
  endtask

  initial begin
    int hi;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    tick(); tick();
    check("rst_done", 32'(done), 0);
    check("rst_res", 32'(res), 0);
    check("rst_err", 32'(err), 0);
    check("rst_gnt", 32'(gnt_id), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_start", 32'(sum_start), 0);
    check("rst_sum_ab", {sum_a, sum_b}, 0);
    rst = 1'b0;

    // 1: single requester
    req = 4'b0001; set_op(0, 3, 4);
    wait_done("t1", 4'b0001, 7);
    req = '0;
    tick(); tick();
    check("t1_idle", 32'(busy_o), 0);
    check("t1_starts", 32'(start_rises), 1);
    check("t1_no_err", 32'(err_cnt), 0);

    // 2: all four pending from ptr=0
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    set_op(0, 3, 4); set_op(1, 5, 12); set_op(2, 8, 7); set_op(3, 1, 1);
    wait_done("t2_g0", 4'b0001, 7);  req[0] = 1'b0;
    wait_done("t2_g1", 4'b0010, 17); req[1] = 1'b0;
    wait_done("t2_g2", 4'b0100, 15); req[2] = 1'b0;
    wait_done("t2_g3", 4'b1000, 2);  req[3] = 1'b0;
    tick();

    // 3: move ptr to 1, then 0101 grants 2 before 0; re-raised 2 waits for 0
    req = 4'b0001; set_op(0, 9, 9);
    wait_done("t3_pre", 4'b0001, 18); req = '0;
    tick();
    req = 4'b0101; set_op(0, 10, 20); set_op(2, 100, 200);
    wait_done("t3_g2", 4'b0100, 300);
    set_op(2, 1000, 1);
    wait_done("t3_g0", 4'b0001, 30); req = 4'b0100;
    wait_done("t3_g2b", 4'b0100, 1001); req = '0;
    tick();

    // 4: adder never busy -> timeout, then next requester
    stuck = 1'b1;
    req = 4'b1001; set_op(3, 6, 7); set_op(0, 1, 2);
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (err) break;
      if (sum_start) hi++;
    end
    check("t4_err", 32'(err), 1);
    check("t4_issue_cycles", 32'(hi), 15);
    check("t4_no_done", 32'(done), 0);
    stuck = 1'b0;
    tick();
    check("t4_err_pulse", 32'(err), 0);
    check("t4_next_busy", 32'(busy_o), 1);
    check("t4_next_gnt", 32'(gnt_id), 0);
    wait_done("t4_g0", 4'b0001, 3); req = 4'b1000;
    wait_done("t4_g3", 4'b1000, 13); req = '0;
    tick();

    // 5: reset during WAIT clears state and ptr
    req = 4'b0100; set_op(2, 50, 5);
    wait_done("t5_pre", 4'b0100, 55); req = '0;
    tick();
    req = 4'b0010; set_op(1, 9, 9);
    wait_in_wait("t5");
    rst = 1'b1;
    tick();
    check("t5_busy", 32'(busy_o), 0);
    check("t5_start", 32'(sum_start), 0);
    check("t5_done", 32'(done), 0);
    check("t5_res", 32'(res), 0);
    check("t5_gnt", 32'(gnt_id), 0);
    rst = 1'b0;
    req = 4'b1010; set_op(1, 2, 2); set_op(3, 5, 5);
    wait_done("t5_g1", 4'b0010, 4); req = 4'b1000;
    wait_done("t5_g3", 4'b1000, 10); req = '0;
    tick();

    // 6: requester drops req and changes operands after grant
    req = 4'b0010; set_op(1, 40, 2);
    wait_in_wait("t6");
    req = '0; set_op(1, 16'hffff, 16'hffff);
    check("t6_sum_a_held", 32'(sum_a), 40);
    wait_done("t6_g1", 4'b0010, 42);
    tick();
    check("t6_after_done", 32'(done), 0);
    tick();
    check("t6_idle", 32'(busy_o), 0);
    check("t6_res_hold", 32'(res), 42);

    tick();
    check("total_done", 32'(done_cnt), 15);
    check("total_err", 32'(err_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
